// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 16-bit SRAM sequencer: FSM encoding and data-path constants.
package sram_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_LO = 3'd1,
        ST_ACC_HI = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_controller.sv
// Splits a 32-bit MEM-stage load/store into two 16-bit SRAM cycles plus WAIT_CYCLES idle cycles.
// ready drops combinationally on a new request and returns high for one DONE cycle (3+WAIT_CYCLES later).
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam int              CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e               state_q, state_d;
    logic                 op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]    lo_addr_q, lo_addr_d;
    logic [SRAM_DW-1:0]   whi_q, whi_d;
    logic [SRAM_DW-1:0]   rd_lo_q, rd_lo_d;
    logic [SRAM_DW-1:0]   rd_hi_q, rd_hi_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 we_n_q, we_n_d;

    logic                 req;
    logic [ADDR_W-2:0]    word_idx;
    logic [ADDR_W-1:0]    req_lo;

    assign req      = wr_en | rd_en;
    // Offset wraps mod 2^32; bits [1:0] select bytes inside the 32-bit word and are dropped.
    assign word_idx = (ADDR_W-1)'((address - BASE_ADDR) >> 2);
    assign req_lo   = {word_idx, 1'b0};

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        lo_addr_d   = lo_addr_q;
        whi_d       = whi_q;
        rd_lo_d     = rd_lo_q;
        rd_hi_d     = rd_hi_q;
        read_data_d = read_data_q;
        cnt_d       = cnt_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_wr_d     = wr_en;
                    lo_addr_d   = req_lo;
                    whi_d       = write_data[31:16];
                    sram_addr_d = req_lo;
                    dq_out_d    = write_data[15:0];
                    dq_oe_d     = wr_en;
                    we_n_d      = ~wr_en;
                    state_d     = ST_ACC_LO;
                end
            end
            ST_ACC_LO: begin
                if (!op_wr_q) rd_lo_d = sram_dq_in;
                sram_addr_d = {lo_addr_q[ADDR_W-1:1], 1'b1};
                dq_out_d    = whi_q;
                dq_oe_d     = op_wr_q;
                we_n_d      = ~op_wr_q;
                state_d     = ST_ACC_HI;
            end
            ST_ACC_HI: begin
                if (!op_wr_q) rd_hi_d = sram_dq_in;
                if (WAIT_CYCLES == 0) begin
                    if (!op_wr_q) read_data_d = {sram_dq_in, rd_lo_q};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!op_wr_q) read_data_d = {rd_hi_q, rd_lo_q};
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            lo_addr_q   <= '0;
            whi_q       <= '0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            read_data_q <= '0;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            lo_addr_q   <= lo_addr_d;
            whi_q       <= whi_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            read_data_q <= read_data_d;
            cnt_q       <= cnt_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // Holding ready high during reset keeps the pipeline from freezing on a stale request.
    assign ready       = (state_q == ST_IDLE) ? (rst | ~req) : (state_q == ST_DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller against a word-level memory model; a second
// instance built with WAIT_CYCLES=0 checks the short-latency configuration.
module tb_sram_controller;

    localparam int          WAIT_CYCLES = 3;
    localparam logic [31:0] BASE        = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en, wr_en_z, rd_en_z;
    logic [31:0] address, write_data;
    logic [31:0] read_data, read_data_z;
    logic        ready, ready_z;
    logic [17:0] sram_addr, sram_addr_z;
    logic [15:0] sram_dq_out, sram_dq_out_z;
    logic        sram_dq_oe, sram_dq_oe_z;
    logic [15:0] sram_dq_in, sram_dq_in_z;
    logic        sram_we_n, sram_we_n_z;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(BASE), .ADDR_W(18), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.BASE_ADDR(BASE), .ADDR_W(18), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en_z), .rd_en(rd_en_z), .address(address),
        .write_data(write_data), .read_data(read_data_z), .ready(ready_z),
        .sram_addr(sram_addr_z), .sram_dq_out(sram_dq_out_z), .sram_dq_oe(sram_dq_oe_z),
        .sram_dq_in(sram_dq_in_z), .sram_we_n(sram_we_n_z)
    );

    // Asynchronous-read SRAM device; only the low 10 address bits are decoded.
    logic [15:0] mem [1024];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
        end else if (!sram_we_n) begin
            mem[sram_addr[9:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in   = mem[sram_addr[9:0]];
    assign sram_dq_in_z = 16'h1234;

    // Reference model: 32-bit words keyed by word index, plus last load result.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    int          n_vec, n_err;

    function automatic logic [31:0] ref_word(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off[18:2]);
    endfunction

    function automatic logic [17:0] lo_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return {off[18:2], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
            #1;
            chk("idle_rdy", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_oe", 32'(sram_dq_oe), 32'd0);
        end
    endtask

    // Leaves the request asserted in DONE so a following call exercises back-to-back issue.
    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input bit perturb);
        logic        is_wr;
        logic [17:0] lo;
        int          cyc, w;
        is_wr = wr;
        lo    = lo_of(addr);
        w     = word_of(addr);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        #1 chk("req_rdy", 32'(ready), 32'd0);
        @(negedge clk);
        chk("lo_addr", 32'(sram_addr), 32'(lo));
        chk("lo_we_n", 32'(sram_we_n), 32'(!is_wr));
        chk("lo_oe", 32'(sram_dq_oe), 32'(is_wr));
        chk("lo_rdy", 32'(ready), 32'd0);
        if (is_wr) chk("lo_dq", 32'(sram_dq_out), 32'(data[15:0]));
        if (perturb) begin
            address = $urandom; write_data = $urandom;
            wr_en = 1'($urandom); rd_en = 1'($urandom);
        end
        @(negedge clk);
        chk("hi_addr", 32'(sram_addr), 32'(lo | 18'd1));
        chk("hi_we_n", 32'(sram_we_n), 32'(!is_wr));
        chk("hi_oe", 32'(sram_dq_oe), 32'(is_wr));
        chk("hi_rdy", 32'(ready), 32'd0);
        if (is_wr) chk("hi_dq", 32'(sram_dq_out), 32'(data[31:16]));
        cyc = 2;
        do begin
            @(negedge clk);
            cyc++;
            if (!ready) begin
                chk("wait_we_n", 32'(sram_we_n), 32'd1);
                chk("wait_oe", 32'(sram_dq_oe), 32'd0);
                chk("wait_addr", 32'(sram_addr), 32'(lo | 18'd1));
            end
        end while (!ready && cyc < 20);
        chk("latency", 32'(cyc), 32'(3 + WAIT_CYCLES));
        if (is_wr) ref_mem[w] = data;
        else       last_rd    = ref_word(w);
        chk("rd_data", read_data, last_rd);
    endtask

    // Pulses reset in the cycle numbered at_cyc (0 = request cycle) of an access.
    task automatic do_abort(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input int at_cyc);
        int w;
        w = word_of(addr);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        repeat (at_cyc) @(negedge clk);
        #1 rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("ab_rdy", 32'(ready), 32'd1);
        chk("ab_we_n", 32'(sram_we_n), 32'd1);
        chk("ab_oe", 32'(sram_dq_oe), 32'd0);
        chk("ab_rdata", read_data, 32'd0);
        chk("ab_addr", 32'(sram_addr), 32'd0);
        last_rd = 32'h0;
        if (wr && at_cyc >= 2) ref_mem[w] = {ref_word(w) >> 16, data[15:0]};
        if (wr && at_cyc >= 3) ref_mem[w] = data;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ab_rel_rdy", 32'(ready), 32'd1);
        idle(1);
    endtask

    initial begin
        logic [31:0] a, d;
        int          op;
        logic        zwr;
        logic [31:0] z_last;
        n_vec = 0; n_err = 0; last_rd = 32'h0; z_last = 32'h0;
        rst = 1'b1; mem_clr = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; wr_en_z = 1'b0; rd_en_z = 1'b0;
        address = 32'h0; write_data = 32'h0;
        #1;
        chk("rst_rdy", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        idle(2);

        do_txn(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
        idle(1);
        do_txn(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1032, 32'h01234567, 1'b0);
        do_txn(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1);
        idle(2);
        do_txn(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b0);
        do_txn(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            a  = BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            d  = $urandom;
            do_txn(op != 1, op != 0, a, d, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        do_txn(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        do_abort(1'b0, 1'b1, 32'd1040, 32'h0, 4);
        do_abort(1'b1, 1'b0, BASE + 32'd400, 32'h13572468, 2);
        do_txn(1'b0, 1'b1, BASE + 32'd400, 32'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 6; i++) begin
            zwr = 1'($urandom);
            a   = BASE + 32'($urandom_range(0, 255)) * 4;
            @(negedge clk);
            wr_en_z = zwr; rd_en_z = ~zwr; address = a; write_data = $urandom;
            #1 chk("z_req_rdy", 32'(ready_z), 32'd0);
            @(negedge clk);
            chk("z_lo_addr", 32'(sram_addr_z), 32'(lo_of(a)));
            chk("z_lo_rdy", 32'(ready_z), 32'd0);
            @(negedge clk);
            chk("z_hi_addr", 32'(sram_addr_z), 32'(lo_of(a) | 18'd1));
            chk("z_hi_rdy", 32'(ready_z), 32'd0);
            @(negedge clk);
            chk("z_done_rdy", 32'(ready_z), 32'd1);
            if (!zwr) z_last = 32'h12341234;
            chk("z_rdata", read_data_z, z_last);
            wr_en_z = 1'b0; rd_en_z = 1'b0;
            #1 chk("z_idle_rdy", 32'(ready_z), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
